full_adder_pipe: RTL and testbench

- Parameterised ripple-carry full adder: adds operands A and B plus a 1-bit carry-in C, giving a WIDTH-bit sum and a carry-out.
- Outputs are registered. Default WIDTH=1 makes it a classic registered 1-bit full adder.
- Leaf arithmetic block for datapaths and teaching examples. It also serves as the building cell for wider adders.

---
 rtl/full_adder_pipe.sv | 107 ++++++++++
 tb/tb_full_adder_pipe.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/full_adder_pipe.sv
// full_adder_pipe: ripple-carry adder for WIDTH-bit operands plus a
// carry-in, with registered outputs and a one-cycle valid pipeline.
// With the default WIDTH=1 it is a classic registered 1-bit full adder.
//
// Parameters:
//   WIDTH      operand and sum width in bits, 1..64
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; clears sum, carry, out_valid
//   in_valid   qualifies A, B, C in this cycle
//   A, B       unsigned WIDTH-bit operands
//   C          carry-in
//   out_valid  high for the one cycle after an accepted operand set
//   sum        registered (A + B + C) mod 2^WIDTH
//   carry      registered carry-out, bit WIDTH of A + B + C
//   ovf        registered signed overflow, c_WIDTH ^ c_(WIDTH-1)
//              (present only when FULL_ADDER_OVF_EN is defined)
//
// Configuration macro: FULL_ADDER_OVF_EN adds the ovf output and its logic.
// When an operand set is not valid, every output register holds its value,
// so unknowns on A/B/C in idle cycles never reach the outputs.
module full_adder_pipe #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // One full-adder bit cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic ci);
    logic s;
    logic co;
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
    return {co, s};
  endfunction

  // c_s[i] is the carry into bit i; c_s[0] is the external carry-in.
  logic [WIDTH:0]   c_s;
  logic [WIDTH-1:0] sum_s;
  logic [1:0]       cell_s;

  // Ripple the carry combinationally from bit 0 upward.
  always_comb begin
    c_s    = {(WIDTH+1){1'b0}};
    sum_s  = {WIDTH{1'b0}};
    cell_s = 2'b00;
    c_s[0] = C;
    for (int i = 0; i < WIDTH; i++) begin
      cell_s     = fa_cell(A[i], B[i], c_s[i]);
      sum_s[i]   = cell_s[0];
      c_s[i+1]   = cell_s[1];
    end
  end

  // Output registers: reset wins, load on valid, otherwise hold data and drop valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= {WIDTH{1'b0}};
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum       <= sum_s;
      carry     <= c_s[WIDTH];
      out_valid <= 1'b1;
    end else begin
      sum       <= sum;
      carry     <= carry;
      out_valid <= 1'b0;
    end
  end

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  // For WIDTH=1 the carry into the sign bit is C itself (c_s[0]).
  logic ovf_s;

  // Overflow flag derived from the two top carries of the ripple chain.
  always_comb begin
    ovf_s = c_s[WIDTH] ^ c_s[WIDTH-1];
  end

  // Overflow register tracks carry: reset to 0, load on valid, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= ovf_s;
    end else begin
      ovf <= ovf;
    end
  end
`endif

endmodule

// File: tb/tb_full_adder_pipe.sv
// Self-checking bench for full_adder_pipe: three instances (WIDTH 1, 8, 16)
// share clock and reset. Directed vectors cover the truth table, reset,
// hold and wrap cases; the WIDTH=16 instance then sees random traffic
// checked against an arithmetic model (A + B + C, signed range test).
module tb_full_adder_pipe;

  logic clk = 1'b0;
  logic rst_n;

  logic        v1, a1, b1, c1, ov1, co1, s1;
  logic        v8, c8, ov8, co8;
  logic [7:0]  a8, b8, s8;
  logic        v16, c16, ov16, co16;
  logic [15:0] a16, b16, s16;
`ifdef FULL_ADDER_OVF_EN
  logic f1, f8, f16;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  full_adder_pipe #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1), .C(c1),
    .out_valid(ov1), .sum(s1), .carry(co1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f1)
`endif
  );

  full_adder_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .A(a8), .B(b8), .C(c8),
    .out_valid(ov8), .sum(s8), .carry(co8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f8)
`endif
  );

  full_adder_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .A(a16), .B(b16), .C(c16),
    .out_valid(ov16), .sum(s16), .carry(co16)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f16)
`endif
  );

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Signed overflow of a + b + c when a, b are w-bit two's-complement values.
  function automatic logic ref_ovf(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic c);
    longint lim, sa, sb, r;
    lim = longint'(1) << (w - 1);
    sa  = a[w-1] ? longint'(a) - (lim << 1) : longint'(a);
    sb  = b[w-1] ? longint'(b) - (lim << 1) : longint'(b);
    r   = sa + sb + longint'(c);
    return (r >= lim) || (r < -lim);
  endfunction

  logic [1:0]  tt [8];
  logic [16:0] exp_tot;
  logic        exp_vld;
  logic        exp_ovf;

  initial begin
    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // Reset held two cycles with valid operands on every instance.
    rst_n = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    v16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_w1", 65'({ov1, co1, s1}), 65'(0));
      check("rst_w8", 65'({ov8, co8, s8}), 65'(0));
      check("rst_w16", 65'({ov16, co16, s16}), 65'(0));
`ifdef FULL_ADDER_OVF_EN
      check("rst_ovf", 65'({f1, f8, f16}), 65'(0));
`endif
    end
    rst_n = 1'b1;
    v8 = 1'b0; v16 = 1'b0;
    tick();
    check("post_rst_w1", 65'({ov1, co1, s1}), 65'(3'b111));

    // Exhaustive 1-bit truth table, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      {a1, b1, c1} = abc;
      tick();
      check($sformatf("tt_%0d", i), 65'({ov1, co1, s1}), 65'({1'b1, tt[i]}));
`ifdef FULL_ADDER_OVF_EN
      check($sformatf("tt_ovf_%0d", i), 65'(f1), 65'(ref_ovf(1, 64'(abc[2]), 64'(abc[1]), abc[0])));
`endif
    end

    // Hold: idle cycles with unknown operands leave sum/carry unchanged.
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    tick();
    check("hold_load", 65'({ov1, co1, s1}), 65'(3'b101));
    v1 = 1'b0; a1 = 1'bx; b1 = 1'bx; c1 = 1'bx;
    tick();
    check("hold_1", 65'({ov1, co1, s1}), 65'(3'b001));
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    tick();
    check("hold_2", 65'({ov1, co1, s1}), 65'(3'b001));

    // WIDTH=8 wrap and signed overflow.
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
    tick();
    check("w8_wrap", 65'({ov8, co8, s8}), 65'({1'b1, 1'b1, 8'h00}));
`ifdef FULL_ADDER_OVF_EN
    check("w8_wrap_ovf", 65'(f8), 65'(0));
`endif
    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
    tick();
    check("w8_7f", 65'({ov8, co8, s8}), 65'({1'b1, 1'b0, 8'h80}));
`ifdef FULL_ADDER_OVF_EN
    check("w8_7f_ovf", 65'(f8), 65'(1));
`endif

    // Back-to-back valid vectors.
    a8 = 8'h10; b8 = 8'h20; c8 = 1'b0;
    tick();
    check("b2b_0", 65'({ov8, co8, s8}), 65'({1'b1, 1'b0, 8'h30}));
    a8 = 8'hF0; b8 = 8'h20; c8 = 1'b1;
    tick();
    check("b2b_1", 65'({ov8, co8, s8}), 65'({1'b1, 1'b1, 8'h11}));
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    tick();
    check("b2b_2", 65'({ov8, co8, s8}), 65'({1'b1, 1'b0, 8'h00}));
    v8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    tick();
    check("b2b_idle", 65'({ov8, co8, s8}), 65'({1'b0, 1'b0, 8'h00}));

    // Mid-stream reset discards the in-flight result; next valid is normal.
    v16 = 1'b1; a16 = 16'h8000; b16 = 16'h8000; c16 = 1'b1;
    tick();
    check("mid_load", 65'({ov16, co16, s16}), 65'({1'b1, 1'b1, 16'h0001}));
    rst_n = 1'b0; a16 = 16'h1111; b16 = 16'h2222; c16 = 1'b0;
    tick();
    check("mid_rst", 65'({ov16, co16, s16}), 65'(0));
    rst_n = 1'b1; a16 = 16'h1234; b16 = 16'h4321; c16 = 1'b1;
    tick();
    check("mid_after", 65'({ov16, co16, s16}), 65'({1'b1, 1'b0, 16'h5556}));

    // Random WIDTH=16 traffic: 1000 valid vectors interleaved with idle cycles.
    exp_tot = 17'h05556;
    exp_ovf = ref_ovf(16, 64'h1234, 64'h4321, 1'b1);
    for (int i = 0; i < 1200; i++) begin
      v16 = (i % 6) != 5;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      if (v16) begin
        exp_tot = 17'(a16) + 17'(b16) + 17'(c16);
        exp_ovf = ref_ovf(16, 64'(a16), 64'(b16), c16);
      end
      exp_vld = v16;
      tick();
      check($sformatf("rnd_%0d", i), 65'({ov16, co16, s16}), 65'({exp_vld, exp_tot}));
`ifdef FULL_ADDER_OVF_EN
      check($sformatf("rnd_ovf_%0d", i), 65'(f16), 65'(exp_ovf));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
